gol_gen_scheduler: RTL
======================

Name: gol_gen_scheduler

Overview:
- Sequences generation updates of the Game-of-Life grid register and datapath.
- Decides when the next-state grid is committed: continuous run at a programmable rate, single-step, or clear.
- Arbitrates cell-edit access so edits land only while paused.
- Stops itself when the grid reaches a still life. Sits between the button controller and the grid register/evolve datapath.

Parameters:
- ROWS, 8, grid rows
- COLS, 8, grid columns
- PERIOD, 4, clock cycles from one run-mode commit to the next (>=2)
- GEN_W, 16, generation counter width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- run_toggle  in  1  one-cycle pulse; toggles run/pause
- step  in  1  one-cycle pulse; single generation while paused
- clear  in  1  one-cycle pulse; request an all-dead grid
- edit_req  in  1  level; cursor toggle wants grid write access
- grid_cur  in  ROWS*COLS  current grid register contents
- grid_next  in  ROWS*COLS  datapath next-generation result
- commit_evolve  out  1  one-cycle pulse; grid register loads grid_next
- commit_clear  out  1  one-cycle pulse; grid register loads zero
- edit_ack  out  1  one-cycle pulse; requester may write its cell this cycle
- running  out  1  high in RUN_WAIT/EVOLVE when not single-stepping
- stable  out  1  last evolve found grid_next == grid_cur
- generation  out  GEN_W  generation count, saturating

Behaviour:
- Reset: state PAUSED; all pulses 0; running=0; stable=0; generation=0; tick counter=0; edit_armed=1.
- States: PAUSED, RUN_WAIT, EVOLVE.
- Input priority per cycle: clear > run_toggle > step > edit_req.
- clear, any state:
  - commit_clear=1 that cycle; next state PAUSED; generation=0; stable=0; tick=0.
  - Any other input in the same cycle is ignored.
- PAUSED, run_toggle:
  - Go to RUN_WAIT; tick=0; stable=0; running=1 from the next cycle.
- PAUSED, step: go to EVOLVE with single=1.
- PAUSED, edit_req with edit_armed=1 and no higher-priority input:
  - edit_ack=1 for exactly one cycle; edit_armed=0; stable=0.
  - edit_armed returns to 1 on the first cycle edit_req is low.
- Edit gating:
  - edit_req outside PAUSED is held pending; no ack until PAUSED.
  - edit_ack is never asserted in the same cycle as any commit pulse.
- RUN_WAIT:
  - Tick increments each cycle; at tick==PERIOD-2, go to EVOLVE.
  - run_toggle: go to PAUSED; running=0.
  - step is ignored.
- EVOLVE (one cycle), combinational compare of grid_next vs grid_cur:
  - Equal: no commit; stable=1; generation unchanged; go to PAUSED; running=0.
  - Different: commit_evolve=1; generation+1, saturating at 2^GEN_W-1.
    - If single or run_toggle this cycle: go to PAUSED.
    - Otherwise go to RUN_WAIT with tick=0.
  - Consequence: run-mode commits are exactly PERIOD cycles apart.
- Latency: step pulse at cycle N gives commit_evolve at N+1. run_toggle at N gives first commit at N+PERIOD.
- Empty grid is a still life: running from all-dead sets stable=1 on the first EVOLVE, with no commit.
- Reset mid-run: next cycle PAUSED with all outputs at reset values; no pulse is emitted in the reset cycle.

Decomposition:
- gol_pkg holds:
  - sched_state_t enum {PAUSED, RUN_WAIT, EVOLVE}
  - GRID_BITS = ROWS*COLS helper function/constant
  - shared grid_t vector type
- One natural sub-module: gol_tick_gen, the PERIOD counter with clear input and terminal-count output.
- Next-state logic, edit arbitration and the generation counter stay in gol_gen_scheduler.

Test Plan:
- Blinker, single step:
  - Stimulus: reset; grid_cur=horizontal blinker, grid_next=vertical; step at cycle 5.
  - Response: commit_evolve at cycle 6 only; generation=1; running=0.
- Run rate:
  - Stimulus: PERIOD=4; run_toggle at cycle 10; grid_next always differs from grid_cur.
  - Response: commits at cycles 14, 18, 22; generation 3 after cycle 22; run_toggle at 23 gives no further commits.
- Still life:
  - Stimulus: grid_cur==grid_next (2x2 block) while running.
  - Response: first EVOLVE gives no commit; stable=1; running=0; generation unchanged. A later edit_ack clears stable.
- Edit arbitration:
  - Stimulus: edit_req held high during RUN_WAIT.
  - Response: no ack. run_toggle pauses; edit_ack pulses once on the next PAUSED cycle, not again until edit_req drops and rises.
- Clear priority:
  - Stimulus: clear and run_toggle in the same cycle while running at generation 7.
  - Response: commit_clear=1; generation=0; state PAUSED; no commit_evolve.
- Saturation and reset:
  - Stimulus: GEN_W=3; run 9 differing generations.
  - Response: generation stays at 7. Then assert reset mid-RUN_WAIT: all outputs 0 on the next cycle.

Source files
------------

// File: rtl/gol_pkg.sv
// Shared types and constants for the Game-of-Life generation scheduler.
package gol_pkg;

    typedef enum logic [1:0] {
        PAUSED   = 2'd0,
        RUN_WAIT = 2'd1,
        EVOLVE   = 2'd2
    } sched_state_t;

    localparam int DEF_ROWS = 8;
    localparam int DEF_COLS = 8;

    function automatic int grid_bits(input int rows, input int cols);
        return rows * cols;
    endfunction

    localparam int GRID_BITS = grid_bits(DEF_ROWS, DEF_COLS);

    // Flattened grid, row-major: bit index = row*COLS + col.
    typedef logic [GRID_BITS-1:0] grid_t;

endpackage

// File: rtl/gol_gen_scheduler_if.sv
// Control/grid bundle between the button controller, grid register and scheduler.
interface gol_gen_scheduler_if import gol_pkg::*; #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int GEN_W = 16
) ();
    localparam int GB = grid_bits(ROWS, COLS);

    logic             run_toggle;
    logic             step;
    logic             clear;
    logic             edit_req;
    logic [GB-1:0]    grid_cur;
    logic [GB-1:0]    grid_next;
    logic             commit_evolve;
    logic             commit_clear;
    logic             edit_ack;
    logic             running;
    logic             stable;
    logic [GEN_W-1:0] generation;

    modport master (
        output run_toggle, step, clear, edit_req, grid_cur, grid_next,
        input  commit_evolve, commit_clear, edit_ack, running, stable, generation
    );

    modport slave (
        input  run_toggle, step, clear, edit_req, grid_cur, grid_next,
        output commit_evolve, commit_clear, edit_ack, running, stable, generation
    );
endinterface

// File: rtl/gol_tick_gen.sv
// Run-rate counter: counts up from zero and holds at PERIOD-2, which it flags as terminal.
module gol_tick_gen #(
    parameter int PERIOD = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tc
);
    localparam int CW = (PERIOD > 2) ? $clog2(PERIOD - 1) : 1;
    localparam logic [CW-1:0] TERM = CW'(PERIOD - 2);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (count_q != TERM) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == TERM);

endmodule

// File: rtl/gol_gen_scheduler.sv
// Decides when the grid register commits the next generation or clears, and when
// cell edits may land; pauses itself once the grid stops changing.
module gol_gen_scheduler import gol_pkg::*; #(
    parameter int ROWS   = 8,
    parameter int COLS   = 8,
    parameter int PERIOD = 4,
    parameter int GEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    gol_gen_scheduler_if.slave bus
);
    localparam logic [GEN_W-1:0] GEN_MAX = '1;

    sched_state_t     state_q, state_d;
    logic             single_q, single_d;
    logic             running_q, running_d;
    logic             stable_q, stable_d;
    logic             armed_q, armed_d;
    logic [GEN_W-1:0] gen_q, gen_d;

    logic             evolve_pulse;
    logic             clear_pulse;
    logic             ack_pulse;
    logic             tick_clr;
    logic             tick_tc;
    logic [ROWS-1:0]  row_eq;
    logic             grids_equal;

    // Row-by-row compare keeps each comparator COLS wide.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_cmp
        assign row_eq[gi] = (bus.grid_next[gi*COLS +: COLS] == bus.grid_cur[gi*COLS +: COLS]);
    end
    assign grids_equal = &row_eq;

    always_comb begin
        state_d      = state_q;
        single_d     = single_q;
        stable_d     = stable_q;
        armed_d      = armed_q;
        gen_d        = gen_q;
        evolve_pulse = 1'b0;
        clear_pulse  = 1'b0;
        ack_pulse    = 1'b0;

        if (bus.clear) begin
            clear_pulse = 1'b1;
            state_d     = PAUSED;
            single_d    = 1'b0;
            stable_d    = 1'b0;
            gen_d       = '0;
        end else begin
            unique case (state_q)
                PAUSED: begin
                    if (bus.run_toggle) begin
                        state_d  = RUN_WAIT;
                        stable_d = 1'b0;
                    end else if (bus.step) begin
                        state_d  = EVOLVE;
                        single_d = 1'b1;
                    end else if (bus.edit_req && armed_q) begin
                        ack_pulse = 1'b1;
                        armed_d   = 1'b0;
                        stable_d  = 1'b0;
                    end
                end
                RUN_WAIT: begin
                    if (bus.run_toggle) begin
                        state_d = PAUSED;
                    end else if (tick_tc) begin
                        state_d = EVOLVE;
                    end
                end
                EVOLVE: begin
                    single_d = 1'b0;
                    if (grids_equal) begin
                        stable_d = 1'b1;
                        state_d  = PAUSED;
                    end else begin
                        evolve_pulse = 1'b1;
                        stable_d     = 1'b0;
                        gen_d        = (gen_q == GEN_MAX) ? gen_q : gen_q + GEN_W'(1);
                        state_d      = (single_q || bus.run_toggle) ? PAUSED : RUN_WAIT;
                    end
                end
                default: begin
                    state_d  = PAUSED;
                    single_d = 1'b0;
                end
            endcase
        end

        // A held request is acknowledged once; it must drop before it can win again.
        if (!bus.edit_req) begin
            armed_d = 1'b1;
        end

        running_d = (state_d == RUN_WAIT) || ((state_d == EVOLVE) && !single_d);
    end

    // The tick restarts from zero every time RUN_WAIT is (re)entered.
    assign tick_clr = !((state_q == RUN_WAIT) && (state_d == RUN_WAIT));

    gol_tick_gen #(
        .PERIOD (PERIOD)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (tick_clr),
        .tc    (tick_tc)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= PAUSED;
            single_q  <= 1'b0;
            running_q <= 1'b0;
            stable_q  <= 1'b0;
            armed_q   <= 1'b1;
            gen_q     <= '0;
        end else begin
            state_q   <= state_d;
            single_q  <= single_d;
            running_q <= running_d;
            stable_q  <= stable_d;
            armed_q   <= armed_d;
            gen_q     <= gen_d;
        end
    end

    // Pulses are suppressed while reset is asserted so the grid register is untouched.
    assign bus.commit_evolve = evolve_pulse & ~reset;
    assign bus.commit_clear  = clear_pulse & ~reset;
    assign bus.edit_ack      = ack_pulse & ~reset;
    assign bus.running       = running_q;
    assign bus.stable        = stable_q;
    assign bus.generation    = gen_q;

endmodule
